// File: rtl/enemy_fire_if.sv
// enemy_fire_if: scheduler-side bundle of gameplay inputs and fire outputs
interface enemy_fire_if #(
   parameter int N_ENEMIES = 8,
   parameter int IDX_W = 4
);
   logic enable;
   logic [N_ENEMIES-1:0] enemy_alive;
   logic [N_ENEMIES-1:0] missile_on;
   logic [N_ENEMIES-1:0] fire;
   logic [IDX_W-1:0] fire_idx;
   logic [IDX_W-1:0] active_cnt;
   modport master (output enable, enemy_alive, missile_on, input fire, fire_idx, active_cnt);
   modport slave (input enable, enemy_alive, missile_on, output fire, fire_idx, active_cnt);
endinterface

// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler: periodic, LFSR-seeded round-robin enemy missile launcher
// with a cap on missiles simultaneously in flight.
module enemy_fire_scheduler #(
   parameter int N_ENEMIES = 8,
   parameter int IDX_W = 4,
   parameter int PERIOD = 2000000,
   parameter int MAX_ACTIVE = 3,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input logic pclk,
   input logic rst,
   enemy_fire_if.slave bus
);
   localparam int LOG = $clog2(N_ENEMIES);
   localparam int CW = PERIOD > 2 ? $clog2(PERIOD) : 1;
   typedef enum logic [2:0] {WAIT, PICK, SCAN, FIRE, HOLD1, HOLD2} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [LOG-1:0] start_q, start_d, k_q, k_d, idx;
   logic [N_ENEMIES-1:0] fire_q, fire_d;
   logic [IDX_W-1:0] fire_idx_q, fire_idx_d, active_cnt_q, active_cnt_d;
   logic eligible;
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      active_cnt_d = '0;
      for (int i = 0; i < N_ENEMIES; i++) active_cnt_d = active_cnt_d + IDX_W'(bus.missile_on[i]);
   end
   // candidate index wraps naturally in LOG bits
   assign idx = start_q + k_q;
   assign eligible = bus.enemy_alive[idx] & ~bus.missile_on[idx];
   always_comb begin
      state_d = state_q;
      cnt_d = '0;
      start_d = start_q;
      k_d = k_q;
      fire_idx_d = fire_idx_q;
      if (!bus.enable) state_d = WAIT;
      else begin
         case (state_q)
            WAIT: begin
               state_d = cnt_q == CW'(PERIOD - 1) ? PICK : WAIT;
               cnt_d = cnt_q == CW'(PERIOD - 1) ? '0 : cnt_q + 1'b1;
            end
            PICK: begin
               start_d = lfsr_q[LOG-1:0];
               k_d = '0;
               state_d = active_cnt_q >= IDX_W'(MAX_ACTIVE) ? WAIT : SCAN;
            end
            SCAN: begin
               fire_idx_d = eligible ? IDX_W'(idx) : fire_idx_q;
               state_d = eligible ? FIRE : (k_q == LOG'(N_ENEMIES - 1) ? WAIT : SCAN);
               k_d = k_q + 1'b1;
            end
            FIRE: state_d = HOLD1;
            HOLD1: state_d = HOLD2;
            default: state_d = WAIT;
         endcase
      end
      fire_d = state_d == FIRE ? N_ENEMIES'(1) << idx : '0;
   end
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q <= WAIT;
         cnt_q <= '0;
         lfsr_q <= LFSR_SEED;
         start_q <= '0;
         k_q <= '0;
         fire_q <= '0;
         fire_idx_q <= '0;
         active_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         lfsr_q <= lfsr_d;
         start_q <= start_d;
         k_q <= k_d;
         fire_q <= fire_d;
         fire_idx_q <= fire_idx_d;
         active_cnt_q <= active_cnt_d;
      end
   end
   assign bus.fire = fire_q;
   assign bus.fire_idx = fire_idx_q;
   assign bus.active_cnt = active_cnt_q;
endmodule

// File: doc/enemy_fire_scheduler.md
Name: enemy_fire_scheduler

Overview:
Decides when and which enemy launches a missile. One instance drives the missle_button inputs of all per-enemy missile controllers. It fires periodically with a pseudo-random start point and a round-robin scan, and caps how many missiles are on screen at once. It sits between the enemy formation logic (alive flags) and the bank of per-enemy missile controllers (whose on_out flags feed back as busy).

Parameters:
N_ENEMIES, 8, number of enemy missile slots; legal values 2, 4, 8, 16 (power of two).
IDX_W, 4, width of fire_idx and active_cnt; must satisfy 2^IDX_W > N_ENEMIES.
PERIOD, 2000000, pclk cycles between fire attempts (~30 ms at 65 MHz).
MAX_ACTIVE, 3, maximum simultaneous enemy missiles in flight.
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
pclk  input  1  clock
rst  input  1  synchronous, active-high reset
enable  input  1  gameplay running; low freezes scheduling
enemy_alive  input  N_ENEMIES  bit i high = enemy i alive
missile_on  input  N_ENEMIES  bit i high = missile i in flight (on_out of controller i)
fire  output  N_ENEMIES  one-hot, one-cycle fire pulse to controller i's missle_button
fire_idx  output  IDX_W  index of last enemy fired
active_cnt  output  IDX_W  registered popcount of missile_on

Behaviour:
- All outputs are registered. Reset values: fire=0, fire_idx=0, active_cnt=0, state=WAIT, period counter=0, LFSR=LFSR_SEED.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every cycle regardless of state or enable, but not during reset.
- active_cnt is the popcount of missile_on, sampled each cycle, with 1-cycle latency.
- Eligible(i) = enemy_alive[i] & ~missile_on[i].
- State machine:
  - WAIT: if enable=0, counter is held at 0. Otherwise the counter increments. When it reaches PERIOD-1, the counter clears and the FSM goes to PICK.
  - PICK: start = LFSR[log2(N_ENEMIES)-1:0] and k=0. If active_cnt >= MAX_ACTIVE, go to WAIT (attempt skipped). Otherwise go to SCAN.
  - SCAN: examines one candidate per cycle, idx = (start+k) mod N_ENEMIES.
    - If Eligible(idx): latch fire_idx=idx and go to FIRE.
    - Else if k=N_ENEMIES-1: go to WAIT (no eligible enemy).
    - Else k=k+1.
  - FIRE: fire[fire_idx]=1 for exactly this one cycle, then go to HOLD.
  - HOLD: stays 2 cycles, which covers the missile controller's IDLE->SHOOT->on_out latency so the slot is not double-counted. Then go to WAIT.
- Worst-case latency from the period tick to the fire pulse: 1 (PICK) + N_ENEMIES (SCAN) + 1 cycles.
- enable dropping mid-sequence: from any state the FSM returns to WAIT on the next cycle, the counter clears to 0, and no fire pulse is issued. A FIRE state already registered still completes its single pulse.
- Enemy dies or missile_on rises during SCAN: eligibility is evaluated live per cycle, and only the current idx matters.
- Exactly one fire bit can be high in any cycle; fire is never asserted outside FIRE.
- rst in any state returns the block to reset values on the next edge. A pulse in flight is dropped.

Test Plan:
1. PERIOD=16, all alive, missile_on=0, enable=1 from reset → first fire pulse exactly 16+1+(SCAN cycles)+1 cycles after rst deassert. fire is one-hot, 1 cycle wide, and fire_idx equals its bit position.
2. enemy_alive=8'b0000_0001, force start index 3 via LFSR_SEED → SCAN visits 3,4,5,6,7,0 and fires enemy 0 after 6 SCAN cycles. fire=8'h01, fire_idx=0.
3. missile_on=8'b0000_0111 (active_cnt=3), MAX_ACTIVE=3 → no fire over 10 periods. Clear one missile_on bit → a fire occurs on the next period.
4. enemy_alive=0 → FSM cycles WAIT→PICK→SCAN(8)→WAIT each period and fire stays 0.
5. Drop enable during SCAN → no pulse, counter reads 0. Re-enable → the next fire comes a full PERIOD later.
6. Assert rst during HOLD and during FIRE → fire=0, fire_idx=0, active_cnt=0 on the following cycle, and the LFSR equals LFSR_SEED.
